// File: rtl/sram_i_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_i_reader                                                 |
// | Purpose  : Streaming read controller for the input feature-map SRAM.     |
// |            Walks a strided, wrapping address sequence and delivers the   |
// |            words on a valid/ready stream through a 2-entry output FIFO.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sram_i_reader #(
   parameter int WORD_AMOUNT  = 3136,
   parameter int BIT_PER_WORD = 145,
   parameter int ADDR_W       = $clog2(WORD_AMOUNT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [ADDR_W:0]         num_words,
   input  logic [ADDR_W-1:0]       stride,
   input  logic                    abort,
   output logic [ADDR_W-1:0]       sram_addr,
   output logic                    sram_we,
   input  logic [BIT_PER_WORD-1:0] sram_dout,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [BIT_PER_WORD-1:0] m_data,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_err
);

   localparam logic [ADDR_W:0] c_word_amount = (ADDR_W+1)'(WORD_AMOUNT);
   localparam logic [ADDR_W:0] c_one         = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   // Command registers and progress counters
   logic [ADDR_W-1:0]       r_addr;      // address currently presented to the SRAM
   logic [ADDR_W-1:0]       r_stride;
   logic [ADDR_W:0]         r_num;
   logic [ADDR_W:0]         r_issued;    // reads committed so far
   logic [ADDR_W:0]         r_beats;     // handshakes completed so far
   logic                    r_rd_pend;   // a read was issued last cycle; its data is on sram_dout now
   logic                    r_done;
   logic                    r_cfg_err;

   // Output FIFO: head register drives m_data directly
   logic [1:0]              r_cnt;
   logic [BIT_PER_WORD-1:0] r_head;
   logic [BIT_PER_WORD-1:0] r_tail;

   logic                    w_cfg_bad;
   logic                    w_accept;
   logic                    w_abort;
   logic                    w_pop;
   logic                    w_issue;
   logic                    w_last_beat;
   logic [2:0]              w_occ;
   logic [ADDR_W:0]         w_sum;
   logic [ADDR_W-1:0]       w_next_addr;

   assign w_cfg_bad   = ({1'b0, base_addr} >= c_word_amount) ||
                        (stride == '0) ||
                        ({1'b0, stride} >= c_word_amount);
   assign w_accept    = (r_state == S_IDLE) && start && !w_cfg_bad && (num_words != '0);
   assign w_abort     = abort && (r_state != S_IDLE);
   assign w_pop       = m_valid && m_ready;

   // Words that will sit in the FIFO once the in-flight read lands; a new read
   // is only committed when its word is guaranteed a slot.
   assign w_occ       = {1'b0, r_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
   assign w_issue     = (r_state == S_RUN) && !abort && (r_issued < r_num) && (w_occ < 3'd2);

   // Sum is formed one bit wider so the wrap test sees the true value
   assign w_sum       = {1'b0, r_addr} + {1'b0, r_stride};
   assign w_next_addr = (w_sum >= c_word_amount) ? ADDR_W'(w_sum - c_word_amount)
                                                 : ADDR_W'(w_sum);

   assign w_last_beat = (r_state == S_DRAIN) && w_pop && ((r_beats + c_one) == r_num);

   assign sram_addr   = r_addr;
   assign sram_we     = 1'b0;
   assign m_valid     = (r_cnt != 2'd0);
   assign m_data      = r_head;
   assign done        = r_done;
   assign cfg_err     = r_cfg_err;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and busy flag
   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (abort)                  w_state_nxt = S_IDLE;
            else if (r_issued == r_num) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort || w_last_beat) w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Command capture, address walk, counters and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_stride  <= '0;
         r_num     <= '0;
         r_issued  <= '0;
         r_beats   <= '0;
         r_rd_pend <= 1'b0;
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cfg_err <= 1'b0;
         if (r_state == S_IDLE) begin
            r_rd_pend <= 1'b0;
            if (start) begin
               if (w_cfg_bad) begin
                  r_cfg_err <= 1'b1;
               end else if (num_words == '0) begin
                  r_done <= 1'b1;
               end else begin
                  r_addr   <= base_addr;
                  r_stride <= stride;
                  r_num    <= num_words;
                  r_issued <= '0;
                  r_beats  <= '0;
               end
            end
         end else if (abort) begin
            // The read in flight is dropped; its data is never pushed
            r_rd_pend <= 1'b0;
         end else begin
            r_rd_pend <= w_issue;
            if (w_issue) begin
               r_addr   <= w_next_addr;
               r_issued <= r_issued + c_one;
            end
            if (w_pop) begin
               r_beats <= r_beats + c_one;
            end
            if (w_last_beat) begin
               r_done <= 1'b1;
            end
         end
      end
   end

   // Two-entry output FIFO; push and pop in the same cycle are both honoured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else if (w_abort) begin
         r_cnt <= 2'd0;
      end else begin
         case ({r_rd_pend, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  r_head <= sram_dout;
                  r_cnt  <= 2'd1;
               end else begin
                  r_tail <= sram_dout;
                  r_cnt  <= 2'd2;
               end
            end
            2'b01: begin
               if (r_cnt == 2'd2) r_head <= r_tail;
               r_cnt <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd1) begin
                  r_head <= sram_dout;
               end else begin
                  r_head <= r_tail;
                  r_tail <= sram_dout;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_i_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sram_i_reader                                              |
// | Purpose  : Directed self-checking bench for sram_i_reader.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sram_i_reader;

   localparam int WA = 3136;
   localparam int BW = 145;
   localparam int AW = 12;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          start     = 1'b0;
   logic          abort     = 1'b0;
   logic          m_ready   = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] stride    = '0;
   logic [AW:0]   num_words = '0;
   logic [BW-1:0] sram_dout = '0;
   logic [AW-1:0] sram_addr;
   logic          sram_we;
   logic          m_valid;
   logic [BW-1:0] m_data;
   logic          busy;
   logic          done;
   logic          cfg_err;

   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   logic [BW-1:0] q_data[$];
   int            q_cyc[$];

   sram_i_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .stride    (stride),
      .abort     (abort),
      .sram_addr (sram_addr),
      .sram_we   (sram_we),
      .sram_dout (sram_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   // Distinct, address-dependent content for every SRAM word
   function automatic logic [BW-1:0] memval(input int a);
      logic [31:0] ua;
      ua = a;
      return {1'b1, ua[15:0], ua, ~ua, (32'hC0DE_0000 | ua), (ua * 32'h9E37_79B1)};
   endfunction

   // SRAM model: one-cycle registered read
   always @(posedge clk) sram_dout <= memval(int'(sram_addr));

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Beat recorder
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         q_data.push_back(m_data);
         q_cyc.push_back(cyc);
      end
   end

   task automatic do_start(input int b, input int n, input int s, output int t0);
      base_addr = AW'(b);
      num_words = (AW+1)'(n);
      stride    = AW'(s);
      start     = 1'b1;
      t0        = cyc;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (sram_addr !== '0) begin failures++; $display("FAIL reset_sram_addr actual=%0d expected=0", sram_addr); end
      checks++; if (sram_we !== 1'b0) begin failures++; $display("FAIL reset_sram_we actual=%b expected=0", sram_we); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid actual=%b expected=0", m_valid); end
      checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data actual=%h expected=0", m_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", done); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err actual=%b expected=0", cfg_err); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int t0;
      int n;
      m_ready = 1'b1;
      q_data.delete(); q_cyc.delete();
      do_start(0, 4, 1, t0);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         n = cyc - t0;
         if (n <= 4) begin
            checks++; if (sram_addr !== AW'(n - 1)) begin failures++; $display("FAIL basic_addr cyc=%0d actual=%0d expected=%0d", n, sram_addr, n - 1); end
         end
         checks++; if (busy !== (n < 7)) begin failures++; $display("FAIL basic_busy cyc=%0d actual=%b expected=%b", n, busy, (n < 7)); end
         checks++; if (done !== (n == 7)) begin failures++; $display("FAIL basic_done cyc=%0d actual=%b expected=%b", n, done, (n == 7)); end
         @(posedge clk); #1;
      end
      checks++; if (q_data.size() != 4) begin failures++; $display("FAIL basic_beats actual=%0d expected=4", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 4; i++) begin
         checks++;
         if (q_data[i] !== memval(i) || q_cyc[i] != t0 + 3 + i) begin
            failures++;
            $display("FAIL basic_beat%0d data=%h cyc=%0d expected data=%h cyc=%0d", i, q_data[i], q_cyc[i] - t0, memval(i), 3 + i);
         end
      end
   endtask

   task automatic test_wrap();
      int t0;
      int n;
      int ea[5];
      ea = '{3130, 3133, 0, 3, 6};
      m_ready = 1'b1;
      q_data.delete(); q_cyc.delete();
      do_start(3130, 5, 3, t0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n = cyc - t0;
         if (n <= 5) begin
            checks++; if (sram_addr !== AW'(ea[n - 1])) begin failures++; $display("FAIL wrap_addr cyc=%0d actual=%0d expected=%0d", n, sram_addr, ea[n - 1]); end
         end
         if (n == 8) begin
            checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wrap_done done=%b busy=%b expected done=1 busy=0", done, busy); end
         end
         @(posedge clk); #1;
      end
      checks++; if (q_data.size() != 5) begin failures++; $display("FAIL wrap_beats actual=%0d expected=5", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 5; i++) begin
         checks++; if (q_data[i] !== memval(ea[i])) begin failures++; $display("FAIL wrap_beat%0d actual=%h expected=%h", i, q_data[i], memval(ea[i])); end
      end
   endtask

   task automatic test_stall();
      int            t0;
      int            n;
      logic          pv;
      logic          pr;
      logic [BW-1:0] pd;
      logic [63:0]   pat;
      bit            seen_done;
      pat = 64'hA6D3_5B2E_C97F_1E4B;
      m_ready = 1'b0;
      q_data.delete(); q_cyc.delete();
      do_start(200, 16, 7, t0);
      pv = 1'b0; pr = 1'b0; pd = '0; seen_done = 1'b0;
      for (int k = 0; k < 200 && !seen_done; k++) begin
         n = cyc - t0;
         m_ready = (n >= 10 && n <= 14) ? 1'b0 : ((n < 64) ? pat[n] : 1'b1);
         @(negedge clk);
         if (pv && !pr) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== pd) begin
               failures++;
               $display("FAIL stall_hold cyc=%0d valid=%b data=%h expected valid=1 data=%h", n, m_valid, m_data, pd);
            end
         end
         pv = m_valid; pr = m_ready; pd = m_data;
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (!seen_done) begin failures++; $display("FAIL stall_timeout done=0 expected=1"); end
      checks++; if (q_data.size() != 16) begin failures++; $display("FAIL stall_beats actual=%0d expected=16", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 16; i++) begin
         checks++; if (q_data[i] !== memval((200 + 7 * i) % WA)) begin failures++; $display("FAIL stall_beat%0d actual=%h expected=%h", i, q_data[i], memval((200 + 7 * i) % WA)); end
      end
   endtask

   task automatic test_zero_err();
      int t0;
      int eb[3];
      int es[3];
      eb = '{3136, 0, 10};
      es = '{1, 0, 3136};
      m_ready = 1'b1;
      q_data.delete(); q_cyc.delete();
      do_start(5, 0, 1, t0);
      @(negedge clk);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done actual=%b expected=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy actual=%b expected=0", busy); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL zero_cfg_err actual=%b expected=0", cfg_err); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zero_after done=%b busy=%b expected 0 0", done, busy); end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         do_start(eb[i], 4, es[i], t0);
         @(negedge clk);
         checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL err%0d cfg_err=%b busy=%b expected 1 0", i, cfg_err, busy); end
         @(posedge clk); #1;
         @(negedge clk);
         checks++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL err%0d_after cfg_err=%b busy=%b expected 0 0", i, cfg_err, busy); end
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk); #1;
      checks++; if (q_data.size() != 0) begin failures++; $display("FAIL zero_err_beats actual=%0d expected=0", q_data.size()); end
   endtask

   task automatic test_abort();
      int t0;
      int nb;
      bit seen_done;
      m_ready = 1'b1;
      q_data.delete(); q_cyc.delete();
      do_start(500, 10, 1, t0);
      // start while busy carries a bad config; it must be ignored silently
      base_addr = AW'(4000);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      @(negedge clk);
      checks++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL busy_start cfg_err=%b busy=%b expected 0 1", cfg_err, busy); end
      nb = 0;
      if (m_valid && m_ready) nb++;
      @(posedge clk); #1;
      for (int k = 0; k < 20 && nb < 3; k++) begin
         @(negedge clk);
         if (m_valid && m_ready) nb++;
         @(posedge clk); #1;
      end
      abort   = 1'b1;
      m_ready = 1'b0;
      @(posedge clk); #1;
      abort   = 1'b0;
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL abort_valid actual=%b expected=0", m_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy actual=%b expected=0", busy); end
      seen_done = done;
      @(posedge clk); #1;
      m_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (seen_done) begin failures++; $display("FAIL abort_done actual=1 expected=0"); end
      checks++; if (q_data.size() != 3) begin failures++; $display("FAIL abort_beats actual=%0d expected=3", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 3; i++) begin
         checks++; if (q_data[i] !== memval(500 + i)) begin failures++; $display("FAIL abort_beat%0d actual=%h expected=%h", i, q_data[i], memval(500 + i)); end
      end
      q_data.delete(); q_cyc.delete();
      do_start(100, 2, 1, t0);
      seen_done = 1'b0;
      for (int k = 0; k < 20 && !seen_done; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (!seen_done) begin failures++; $display("FAIL restart_done actual=0 expected=1"); end
      checks++; if (q_data.size() != 2) begin failures++; $display("FAIL restart_beats actual=%0d expected=2", q_data.size()); end
      for (int i = 0; i < q_data.size() && i < 2; i++) begin
         checks++; if (q_data[i] !== memval(100 + i)) begin failures++; $display("FAIL restart_beat%0d actual=%h expected=%h", i, q_data[i], memval(100 + i)); end
      end
   endtask

   task automatic test_reset_drain();
      int t0;
      bit seen_done;
      m_ready = 1'b0;
      q_data.delete(); q_cyc.delete();
      do_start(0, 2, 1, t0);
      repeat (4) @(posedge clk); #1;
      checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL drain_pre valid=%b busy=%b expected 1 1", m_valid, busy); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL arst_m_valid actual=%b expected=0", m_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy actual=%b expected=0", busy); end
      checks++; if (m_data !== '0) begin failures++; $display("FAIL arst_m_data actual=%h expected=0", m_data); end
      checks++; if (sram_addr !== '0) begin failures++; $display("FAIL arst_sram_addr actual=%0d expected=0", sram_addr); end
      checks++; if (done !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL arst_pulses done=%b cfg_err=%b expected 0 0", done, cfg_err); end
      @(posedge clk); #1;
      rst_n   = 1'b1;
      m_ready = 1'b1;
      seen_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (q_data.size() != 0) begin failures++; $display("FAIL arst_beats actual=%0d expected=0", q_data.size()); end
      checks++; if (seen_done) begin failures++; $display("FAIL arst_done actual=1 expected=0"); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_zero_err();
      test_abort();
      test_reset_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
